// File: rtl/matriz_carregador_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | matriz_carregador_if                                                    |
// | Start, element-stream and packed-matrix handshake bundle of the loader. |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface matriz_carregador_if #(
  parameter int LARGURA = 8,
  parameter int DIM_MAX = 5
);
  logic                                 inicio;
  logic [7:0]                           tamanho_in;
  logic                                 in_valid;
  logic                                 in_ready;
  logic signed [LARGURA-1:0]            in_dado;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [DIM_MAX*DIM_MAX*LARGURA-1:0]   matriz;
  logic [7:0]                           tamanho;
  logic                                 ocupado;
  logic                                 erro;

  modport master (
    output inicio, tamanho_in, in_valid, in_dado, out_ready,
    input  in_ready, out_valid, matriz, tamanho, ocupado, erro
  );

  modport slave (
    input  inicio, tamanho_in, in_valid, in_dado, out_ready,
    output in_ready, out_valid, matriz, tamanho, ocupado, erro
  );
endinterface
`default_nettype wire

// File: rtl/matriz_carregador.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | matriz_carregador                                                       |
// | Packs a row-major NxN stream into the DIM_MAX x DIM_MAX matrix bus.     |
// | Optional macro MATRIZ_IDENTIDADE_PAD_EN: identity padding beyond N.     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module matriz_carregador #(
  parameter int LARGURA = 8,
  parameter int DIM_MAX = 5
) (
  input  wire logic          clock,
  input  wire logic          reset_n,
  matriz_carregador_if.slave bus
);

  localparam int c_ne   = DIM_MAX * DIM_MAX;
  localparam int c_busw = c_ne * LARGURA;
  localparam int c_iw   = $clog2(DIM_MAX + 1);
`ifdef MATRIZ_IDENTIDADE_PAD_EN
  localparam bit c_pad_en = 1'b1;
`else
  localparam bit c_pad_en = 1'b0;
`endif

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CARGA  = 2'd1,
    PRONTO = 2'd2
  } estado_t;

  estado_t             r_estado;
  estado_t             w_estado_prox;
  logic [c_busw-1:0]   r_matriz;
  logic [7:0]          r_tamanho;
  logic [c_iw-1:0]     r_linha;
  logic [c_iw-1:0]     r_coluna;
  logic [c_iw-1:0]     r_ultimo;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_ocupado;
  logic                r_erro;
  logic                w_tam_ok;
  logic                w_aceita;
  logic                w_rejeita;
  logic                w_batida;
  logic                w_ultima;
  int                  w_idx;

  // Identity diagonal above the active NxN block keeps a full-size determinant equal to the NxN one.
  function automatic logic [c_busw-1:0] matriz_inicial(input logic [7:0] n);
    logic [c_busw-1:0] m;
    m = '0;
    for (int k = 0; k < DIM_MAX; k++) begin
      if (c_pad_en && (k >= int'(n))) m[(DIM_MAX*k + k)*LARGURA] = 1'b1;
    end
    return m;
  endfunction

  assign w_tam_ok = (bus.tamanho_in != 8'd0) && (int'(bus.tamanho_in) <= DIM_MAX);
  assign w_ultima = (r_linha == r_ultimo) && (r_coluna == r_ultimo);
  assign w_idx    = DIM_MAX * int'(r_linha) + int'(r_coluna);

  always_comb begin
    w_estado_prox = r_estado;
    w_aceita      = 1'b0;
    w_rejeita     = 1'b0;
    w_batida      = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (bus.inicio) begin
          if (w_tam_ok) begin
            w_aceita      = 1'b1;
            w_estado_prox = CARGA;
          end else begin
            w_rejeita = 1'b1;
          end
        end
      end
      CARGA: begin
        if (bus.in_valid && r_in_ready) begin
          w_batida = 1'b1;
          if (w_ultima) w_estado_prox = PRONTO;
        end
      end
      PRONTO: begin
        if (r_out_valid && bus.out_ready) w_estado_prox = OCIOSO;
      end
      default: w_estado_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_estado <= OCIOSO;
    else          r_estado <= w_estado_prox;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_matriz    <= '0;
      r_tamanho   <= 8'd0;
      r_linha     <= '0;
      r_coluna    <= '0;
      r_ultimo    <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_ocupado   <= 1'b0;
      r_erro      <= 1'b0;
    end else begin
      r_in_ready  <= (w_estado_prox == CARGA);
      r_out_valid <= (w_estado_prox == PRONTO);
      r_ocupado   <= (w_estado_prox != OCIOSO);
      r_erro      <= w_rejeita;
      if (w_aceita) begin
        r_matriz  <= matriz_inicial(bus.tamanho_in);
        r_tamanho <= bus.tamanho_in;
        r_ultimo  <= c_iw'(bus.tamanho_in - 8'd1);
        r_linha   <= '0;
        r_coluna  <= '0;
      end else if (w_batida) begin
        for (int e = 0; e < c_ne; e++) begin
          if (e == w_idx) r_matriz[e*LARGURA +: LARGURA] <= bus.in_dado;
        end
        if (r_coluna == r_ultimo) begin
          r_coluna <= '0;
          r_linha  <= r_linha + 1'b1;
        end else begin
          r_coluna <= r_coluna + 1'b1;
        end
      end
    end
  end

  assign bus.matriz    = r_matriz;
  assign bus.tamanho   = r_tamanho;
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.ocupado   = r_ocupado;
  assign bus.erro      = r_erro;

endmodule
`default_nettype wire
